tile_boot_ctrl: RTL and testbench

Parametrised boot/reset sequencer for multi-core tiles. It replaces the single fixed boot-address flop in the current tile wrappers. It holds N_CORES processor cores in reset, stores a per-core boot address, and releases each core through a counted reset-stretch on command. Commands arrive from a NoC-side CSR bridge over a valid/ready interface, and each accepted command returns a one-cycle response.

---
 rtl/tile_boot_ctrl.sv | 152 +++++++++++++++
 tb/tb_tile_boot_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_boot_ctrl.sv
// Boot/reset sequencer for a multi-core tile: per-core boot address storage and
// counted reset-stretch release, driven by a valid/ready command channel.
module tile_boot_ctrl #(
  parameter int unsigned N_CORES            = 2,
  parameter int unsigned ADDR_W             = 32,
  parameter int unsigned RST_HOLD_CYC       = 16,
  parameter logic [ADDR_W-1:0] DEFAULT_BOOT_ADDR = ADDR_W'(32'h8000_0000),
  parameter bit          AUTO_BOOT          = 1'b0,
  localparam int unsigned ID_W              = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                        clk_core,
  input  logic                        arst_core,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [ID_W-1:0]             cmd_core_id,
  input  logic [ADDR_W-1:0]           cmd_data,
  output logic                        resp_valid,
  output logic                        resp_err,
  output logic [ADDR_W-1:0]           resp_data,
  output logic [N_CORES-1:0]          core_rst,
  output logic [N_CORES*ADDR_W-1:0]   core_boot_addr,
  output logic [N_CORES-1:0]          core_running
);

  localparam int unsigned CNT_W = $clog2(RST_HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_HOLD_CYC - 1);

  localparam logic [1:0] OP_SET_ADDR = 2'd0;
  localparam logic [1:0] OP_START    = 2'd1;
  localparam logic [1:0] OP_STOP     = 2'd2;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } core_state_e;

  core_state_e        state_q [N_CORES];
  core_state_e        state_d [N_CORES];
  logic [CNT_W-1:0]   cnt_q   [N_CORES];
  logic [CNT_W-1:0]   cnt_d   [N_CORES];
  logic [ADDR_W-1:0]  addr_q  [N_CORES];
  logic [ADDR_W-1:0]  addr_d  [N_CORES];
  logic               boot_pend_q;
  logic               resp_valid_d;
  logic               resp_err_d;
  logic [ADDR_W-1:0]  resp_data_d;
  logic               id_ok;
  logic               hit_stretch;
  logic               boot_block;
  logic               accept;

  // Command handshake: stall only while the addressed core is stretching its reset.
  always_comb begin
    id_ok       = 32'(cmd_core_id) < N_CORES;
    hit_stretch = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (id_ok && (32'(cmd_core_id) == 32'(i)) && (state_q[i] == STRETCH)) begin
        hit_stretch = 1'b1;
      end
    end
    // The auto-boot cycle owns core 0, so a same-cycle command to it must wait.
    boot_block = AUTO_BOOT && boot_pend_q && (cmd_core_id == '0);
    cmd_ready  = !arst_core && !hit_stretch && !boot_block;
    accept     = cmd_valid && cmd_ready;
  end

  // Next-state, counter, address and response computation for all cores.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      addr_d[i]  = addr_q[i];
    end
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = '0;

    for (int i = 0; i < N_CORES; i++) begin
      if (state_q[i] == STRETCH) begin
        if (cnt_q[i] == '0) state_d[i] = RUN;
        else                cnt_d[i]   = cnt_q[i] - CNT_W'(1);
      end
    end

    if (AUTO_BOOT && boot_pend_q) begin
      state_d[0] = STRETCH;
      cnt_d[0]   = CNT_LOAD;
    end

    if (accept) begin
      resp_valid_d = 1'b1;
      if (!id_ok) resp_err_d = 1'b1;
      for (int i = 0; i < N_CORES; i++) begin
        if (32'(cmd_core_id) == 32'(i)) begin
          case (cmd_op)
            OP_SET_ADDR: begin
              if (state_q[i] == HALT) addr_d[i] = cmd_data;
              else                    resp_err_d = 1'b1;
            end
            OP_START: begin
              if (state_q[i] == HALT) begin
                state_d[i] = STRETCH;
                cnt_d[i]   = CNT_LOAD;
              end else begin
                resp_err_d = 1'b1;
              end
            end
            OP_STOP: begin
              if (state_q[i] == RUN) state_d[i] = HALT;
            end
            default: resp_data_d = ADDR_W'(state_q[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_core or posedge arst_core) begin
    if (arst_core) begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i]      <= HALT;
        cnt_q[i]        <= '0;
        addr_q[i]       <= DEFAULT_BOOT_ADDR;
        core_rst[i]     <= 1'b1;
        core_running[i] <= 1'b0;
      end
      boot_pend_q <= AUTO_BOOT;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_data   <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i]      <= state_d[i];
        cnt_q[i]        <= cnt_d[i];
        addr_q[i]       <= addr_d[i];
        core_rst[i]     <= (state_d[i] != RUN);
        core_running[i] <= (state_d[i] == RUN);
      end
      boot_pend_q <= 1'b0;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      resp_data   <= resp_data_d;
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_addr_out
    assign core_boot_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
  end

endmodule

// File: tb/tb_tile_boot_ctrl.sv
// Bench for tile_boot_ctrl: directed and random commands against a time-based
// reference model (core state derived from the START acceptance cycle).
module tb_tile_boot_ctrl;

  localparam int unsigned HOLD = 16;
  localparam logic [31:0] DEF  = 32'h8000_0000;
  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_QUERY = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 2 cores, no auto boot
  logic        rst, cmd_valid, cmd_ready, resp_valid, resp_err;
  logic [1:0]  cmd_op;
  logic [0:0]  cmd_core_id;
  logic [31:0] cmd_data, resp_data;
  logic [1:0]  core_rst, core_running;
  logic [63:0] core_boot_addr;

  // Aux instance: 3 cores (2-bit id, so id 3 is invalid), auto boot on core 0
  logic        a_rst, a_cmd_valid, a_cmd_ready, a_resp_valid, a_resp_err;
  logic [1:0]  a_cmd_op, a_cmd_core_id;
  logic [31:0] a_cmd_data, a_resp_data;
  logic [2:0]  a_core_rst, a_core_running;
  logic [95:0] a_core_boot_addr;

  tile_boot_ctrl #(.N_CORES(2), .ADDR_W(32), .RST_HOLD_CYC(HOLD),
                   .DEFAULT_BOOT_ADDR(DEF), .AUTO_BOOT(1'b0)) u_dut (
    .clk_core(clk), .arst_core(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_core_id(cmd_core_id), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .core_rst(core_rst), .core_boot_addr(core_boot_addr), .core_running(core_running)
  );

  tile_boot_ctrl #(.N_CORES(3), .ADDR_W(32), .RST_HOLD_CYC(HOLD),
                   .DEFAULT_BOOT_ADDR(DEF), .AUTO_BOOT(1'b1)) u_aux (
    .clk_core(clk), .arst_core(a_rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(a_cmd_op), .cmd_core_id(a_cmd_core_id), .cmd_data(a_cmd_data),
    .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_data(a_resp_data),
    .core_rst(a_core_rst), .core_boot_addr(a_core_boot_addr), .core_running(a_core_running)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a started core is STRETCH for HOLD cycles after its START edge, then RUN.
  bit          m_started [2];
  int          m_start   [2];
  logic [31:0] m_addr    [2];

  function automatic int m_state(input int i);
    if (!m_started[i]) return 0;
    if ((cyc - m_start[i]) < int'(HOLD)) return 1;
    return 2;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 1'b0;
      m_start[i]   = 0;
      m_addr[i]    = DEF;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_core_rst"},     64'(core_rst[i]),     64'(m_state(i) != 2));
      chk({tag, "_core_running"}, 64'(core_running[i]), 64'(m_state(i) == 2));
      chk({tag, "_boot_addr"},    64'(core_boot_addr[i*32 +: 32]), 64'(m_addr[i]));
    end
  endtask

  // Called at a falling edge; returns at a falling edge with cmd_valid low.
  task automatic do_cmd(input logic [1:0] op, input int id, input logic [31:0] data,
                        output int stalls);
    int pre, t;
    logic exp_err;
    logic [31:0] exp_data;
    bit ok;
    cmd_op = op; cmd_core_id = 1'(id); cmd_data = data; cmd_valid = 1'b1;
    stalls = 0; ok = 1'b0;
    #1;
    for (int k = 0; k < 40; k++) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(m_state(id) != 1));
      if (k > 0) chk("resp_idle", 64'(resp_valid), 64'(0));
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      stalls++;
      @(negedge clk); #1;
    end
    if (!ok) begin
      chk("ready_timeout", 64'(ok), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    pre      = m_state(id);
    t        = cyc + 1;
    exp_err  = ((op == OP_SET) || (op == OP_START)) && (pre != 0);
    exp_data = (op == OP_QUERY) ? 32'(pre) : 32'd0;
    @(posedge clk);
    case (op)
      OP_SET:   if (pre == 0) m_addr[id] = data;
      OP_START: if (pre == 0) begin m_started[id] = 1'b1; m_start[id] = t; end
      OP_STOP:  if (pre == 2) m_started[id] = 1'b0;
      default: ;
    endcase
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("resp_valid", 64'(resp_valid), 64'(1));
    chk("resp_err",   64'(resp_err),   64'(exp_err));
    chk("resp_data",  64'(resp_data),  64'(exp_data));
    check_outs("post_cmd");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st, n;
    logic [1:0] op;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_QUERY; cmd_core_id = '0; cmd_data = '0;
    a_rst = 1'b1; a_cmd_valid = 1'b0; a_cmd_op = OP_QUERY; a_cmd_core_id = '0; a_cmd_data = '0;
    m_reset();
    repeat (3) @(negedge clk);

    // Reset state
    cmd_valid = 1'b1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    check_outs("reset");
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_cmd(OP_QUERY, 1, 32'd0, st);

    // Boot core 1 at a new address; reset falls exactly HOLD cycles after acceptance
    do_cmd(OP_SET, 1, 32'h9000_0100, st);
    do_cmd(OP_START, 1, 32'd0, st);
    n = 0;
    while (core_rst[1] === 1'b1 && n < 40) begin
      check_outs("stretch1");
      n++;
      @(negedge clk);
    end
    chk("core1_stretch_len", 64'(n), 64'(HOLD));
    chk("core1_addr", 64'(core_boot_addr[63:32]), 64'(32'h9000_0100));
    chk("core0_untouched", 64'(core_rst[0]), 64'(1));

    // SET_ADDR to a stretching core stalls, then is refused in RUN
    do_cmd(OP_START, 0, 32'd0, st);
    do_cmd(OP_SET, 0, 32'hDEAD_BEEF, st);
    chk("core0_stall_cycles", 64'(st), 64'(HOLD));
    chk("core0_addr_kept", 64'(core_boot_addr[31:0]), 64'(DEF));

    // STOP from RUN, query, then STOP in HALT is a clean no-op
    do_cmd(OP_STOP, 1, 32'd0, st);
    chk("stop_core_rst", 64'(core_rst[1]), 64'(1));
    chk("stop_running", 64'(core_running[1]), 64'(0));
    do_cmd(OP_QUERY, 1, 32'd0, st);
    do_cmd(OP_STOP, 1, 32'd0, st);

    // Random command traffic against the model
    for (int k = 0; k < 60; k++) begin
      op = 2'($urandom_range(0, 3));
      do_cmd(op, int'($urandom_range(0, 1)), $urandom, st);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) begin
          @(negedge clk);
          check_outs("idle");
        end
      end
    end

    // Async reset while core 1 runs restores defaults at once
    do_cmd(OP_STOP, 1, 32'd0, st);
    do_cmd(OP_SET, 1, 32'h1234_5678, st);
    do_cmd(OP_START, 1, 32'd0, st);
    repeat (20) @(negedge clk);
    chk("pre_reset_running", 64'(core_running[1]), 64'(1));
    #3 rst = 1'b1;
    #1;
    chk("async_core_rst", 64'(core_rst), 64'(2'b11));
    chk("async_running", 64'(core_running), 64'(0));
    chk("async_boot_addr", 64'(core_boot_addr), {DEF, DEF});
    chk("async_cmd_ready", 64'(cmd_ready), 64'(0));
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    do_cmd(OP_QUERY, 1, 32'd0, st);

    // Auto boot: core 0 leaves reset 17 edges after release
    @(negedge clk);
    a_rst = 1'b0;
    n = 0;
    while (a_core_rst[0] === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("aux_boot_stall", 64'(a_cmd_ready), 64'(0));
    end
    chk("aux_boot_latency", 64'(n), 64'(HOLD + 1));
    chk("aux_running", 64'(a_core_running), 64'(3'b001));

    // Invalid core id: accepted with error, nothing changes
    @(negedge clk);
    a_cmd_core_id = 2'd3; a_cmd_op = OP_SET; a_cmd_data = $urandom; a_cmd_valid = 1'b1;
    #1;
    chk("bad_id_ready", 64'(a_cmd_ready), 64'(1));
    @(negedge clk);
    a_cmd_valid = 1'b0;
    chk("bad_id_resp_valid", 64'(a_resp_valid), 64'(1));
    chk("bad_id_resp_err", 64'(a_resp_err), 64'(1));
    chk("bad_id_resp_data", 64'(a_resp_data), 64'(0));
    chk("bad_id_core_rst", 64'(a_core_rst), 64'(3'b110));
    for (int i = 0; i < 3; i++) chk("bad_id_addr", 64'(a_core_boot_addr[i*32 +: 32]), 64'(DEF));

    // Reset during auto-boot STRETCH, then the full stretch repeats from HALT
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    a_cmd_core_id = 2'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("aux_mid_stretch_rst", 64'(a_core_rst), 64'(3'b111));
    chk("aux_mid_stretch_ready", 64'(a_cmd_ready), 64'(0));
    #2 a_rst = 1'b1;
    #1;
    chk("aux_async_core_rst", 64'(a_core_rst), 64'(3'b111));
    chk("aux_async_running", 64'(a_core_running), 64'(0));
    chk("aux_async_resp", 64'(a_resp_valid), 64'(0));
    @(negedge clk);
    a_rst = 1'b0;
    n = 0;
    while (a_core_rst[0] === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aux_reboot_latency", 64'(n), 64'(HOLD + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
